// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: it holds the pipeline for load-use,
// data-memory waits and the divider, and squashes younger stages on an M exception.
module pipeline_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_use,
  input  logic       div_req,
  input  logic       mem_req,
  input  logic       mem_ack,
  input  logic       except_valid,
  output logic       pc_en,
  output logic       en_fd,
  output logic       en_de,
  output logic       en_em,
  output logic       flush_de,
  output logic       flush_em,
  output logic       flush_mw,
  output logic       flush_fd,
  output logic       div_start,
  output logic       div_abort,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Memory handshake: mem_req is a level held by M for the whole access; the access
  // completes in the cycle mem_ack is high, and mem_ack is ignored when mem_req is low.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_en     = 1'b0;
    en_fd     = 1'b0;
    en_de     = 1'b0;
    en_em     = 1'b0;
    flush_fd  = 1'b0;
    flush_de  = 1'b0;
    flush_em  = 1'b0;
    flush_mw  = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;
    busy      = 1'b0;
    if (rst) begin
      pc_en = 1'b1;
      en_fd = 1'b1;
      en_de = 1'b1;
      en_em = 1'b1;
      busy  = (state != RUN);
      case (state)
        RUN: begin
          if (except_valid) begin
            flush_fd = 1'b1;
            flush_de = 1'b1;
            flush_em = 1'b1;
          end else if (mem_req && !mem_ack) begin
            pc_en     = 1'b0;
            en_fd     = 1'b0;
            en_de     = 1'b0;
            en_em     = 1'b0;
            flush_mw  = 1'b1;
            state_nxt = MEM_WAIT;
          end else if (div_req) begin
            div_start = 1'b1;
            pc_en     = 1'b0;
            en_fd     = 1'b0;
            en_de     = 1'b0;
            flush_em  = 1'b1;
            cnt_nxt   = CNT_LOAD;
            state_nxt = DIV_WAIT;
          end else if (ld_use) begin
            pc_en    = 1'b0;
            en_fd    = 1'b0;
            flush_de = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state_nxt = RUN;
          end else begin
            pc_en    = 1'b0;
            en_fd    = 1'b0;
            en_de    = 1'b0;
            en_em    = 1'b0;
            flush_mw = 1'b1;
          end
        end
        DIV_WAIT: begin
          if (except_valid) begin
            flush_fd  = 1'b1;
            flush_de  = 1'b1;
            flush_em  = 1'b1;
            div_abort = 1'b1;
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else if (cnt == '0) begin
            // Divider result is valid: let the E instruction advance.
            state_nxt = RUN;
          end else begin
            pc_en    = 1'b0;
            en_fd    = 1'b0;
            en_de    = 1'b0;
            flush_em = 1'b1;
            cnt_nxt  = cnt - 1'b1;
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus random traffic, each cycle
// compared against a cycle-count based model of the stall rules.
module tb_pipeline_stall_ctrl;

  localparam int DIV_CYCLES = 4;
  localparam int W = 11;

  logic clk, rst;
  logic ld_use, div_req, mem_req, mem_ack, except_valid;
  logic pc_en, en_fd, en_de, en_em, flush_de, flush_em, flush_mw, flush_fd;
  logic div_start, div_abort, busy;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;

  // model state: 0 = running, 1 = waiting on memory, 2 = dividing
  int mode = 0;
  int cyc = 0;
  int div_release = 0;
  logic [W-1:0] exp_q[$];

  pipeline_stall_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .ld_use(ld_use), .div_req(div_req), .mem_req(mem_req),
    .mem_ack(mem_ack), .except_valid(except_valid), .pc_en(pc_en), .en_fd(en_fd),
    .en_de(en_de), .en_em(en_em), .flush_de(flush_de), .flush_em(flush_em),
    .flush_mw(flush_mw), .flush_fd(flush_fd), .div_start(div_start),
    .div_abort(div_abort), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ctrl_vec();
    return {pc_en, en_fd, en_de, en_em, flush_fd, flush_de, flush_em, flush_mw,
            div_start, div_abort, busy};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (pc,fd,de,em,ffd,fde,fem,fmw,dst,dab,busy) cyc=%0d",
               tag, got, exp, cyc);
    end
  endtask

  // Expected outputs for this cycle from the stall rules, and the next model mode.
  task automatic model(input logic ld, input logic dv, input logic mq, input logic ma,
                       input logic ex);
    logic pc, fd, de, em, ffd, fde, fem, fmw, ds, da, bz;
    int nmode;
    {pc, fd, de, em} = 4'b1111;
    {ffd, fde, fem, fmw, ds, da} = 6'b0;
    bz = (mode != 0);
    nmode = mode;
    if (mode == 0) begin
      if (ex) {ffd, fde, fem} = 3'b111;
      else if (mq && !ma) begin
        {pc, fd, de, em} = 4'b0000; fmw = 1'b1; nmode = 1;
      end else if (dv) begin
        ds = 1'b1; {pc, fd, de} = 3'b000; fem = 1'b1; nmode = 2;
        div_release = cyc + DIV_CYCLES;
      end else if (ld) begin
        {pc, fd} = 2'b00; fde = 1'b1;
      end
    end else if (mode == 1) begin
      if (ma) nmode = 0;
      else begin
        {pc, fd, de, em} = 4'b0000; fmw = 1'b1;
      end
    end else begin
      if (ex) begin
        {ffd, fde, fem} = 3'b111; da = 1'b1; nmode = 0;
      end else if (cyc >= div_release) nmode = 0;
      else begin
        {pc, fd, de} = 3'b000; fem = 1'b1;
      end
    end
    exp_q.push_back({pc, fd, de, em, ffd, fde, fem, fmw, ds, da, bz});
    mode = nmode;
  endtask

  // driver: one clock cycle with the given inputs, checked before the rising edge
  task automatic step(input string tag, input logic ld, input logic dv, input logic mq,
                      input logic ma, input logic ex);
    @(negedge clk);
    ld_use = ld; div_req = dv; mem_req = mq; mem_ack = ma; except_valid = ex;
    #1;
    model(ld, dv, mq, ma, ex);
    check(tag, ctrl_vec(), exp_q.pop_front());
    cyc++;
  endtask

  task automatic reset_cycles(input string tag, input int n);
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      check(tag, ctrl_vec(), '0);
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    {ld_use, div_req, mem_req, mem_ack, except_valid} = 5'b0;
    #1;
    check("reset_t0", ctrl_vec(), '0);
    reset_cycles("reset_low", 3);
    idle("after_reset", 2);

    // memory stall for 4 cycles, then ack; then a zero-wait access
    for (int i = 0; i < 4; i++) step("mem_stall", 0, 0, 1, 0, 0);
    step("mem_ack", 0, 0, 1, 1, 0);
    step("mem_nowait", 0, 0, 1, 1, 0);
    idle("mem_idle", 1);

    // divide with div_req held through the wait, dropped in the release cycle
    step("div_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < DIV_CYCLES - 1; i++) step("div_hold", 0, 1, 0, 0, 0);
    step("div_release", 0, 0, 0, 0, 0);
    idle("div_idle", 1);

    // exception in the second DIV_WAIT cycle
    step("div_start2", 0, 1, 0, 0, 0);
    step("div_wait1", 0, 0, 0, 0, 0);
    step("div_except", 0, 0, 0, 0, 1);
    step("after_abort", 0, 0, 0, 0, 0);

    // exception beats a memory stall; memory stall beats load-use
    step("except_mem", 0, 0, 1, 0, 1);
    step("after_exc_mem", 0, 0, 0, 0, 0);
    step("mem_over_ld", 1, 0, 1, 0, 0);
    step("mem_wait_ld", 1, 0, 1, 1, 0);
    step("ld_use_only", 1, 0, 0, 0, 0);
    idle("ld_idle", 1);

    // asynchronous reset in DIV_WAIT while cnt==2
    step("div_start3", 0, 1, 0, 0, 0);
    step("div_wait_c3", 0, 0, 0, 0, 0);
    reset_cycles("reset_in_div", 1);
    idle("post_div_reset", 3);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) reset_cycles("rand_reset", $urandom_range(1, 2));
      else begin
        logic ld, dv, mq, ma, ex;
        ld = ($urandom_range(0, 3) == 0);
        dv = ($urandom_range(0, 7) == 0);
        mq = ($urandom_range(0, 2) == 0);
        ma = ($urandom_range(0, 1) == 0);
        ex = ($urandom_range(0, 15) == 0);
        step("random", ld, dv, mq, ma, ex);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
